// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle right shifter, logical or arithmetic.
// Shifts one bit per clock under a start/busy/done handshake.
// Optional build macro SHIFT_FAST_STEP_EN: step by 4 while at least 4 bits remain.
module serial_right_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               fill;

`ifdef SHIFT_FAST_STEP_EN
    localparam logic [SHAMT_W-1:0] FastStep = SHAMT_W'(4);
`endif

    // Sign copy in arithmetic mode, zero otherwise.
    assign fill = mode_q & data_q[WIDTH-1];

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            data_q   <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: accept in idle, shift until count is exhausted, pulse done.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        count_d  = count_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (start) begin
                    data_d  = data_in;
                    count_d = shamt;
                    mode_d  = arith;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (count_q == '0) begin
                    result_d = data_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StDone;
                end else begin
`ifdef SHIFT_FAST_STEP_EN
                    if (count_q >= FastStep) begin
                        data_d  = {{4{fill}}, data_q[WIDTH-1:4]};
                        count_d = count_q - FastStep;
                    end else begin
                        data_d  = {fill, data_q[WIDTH-1:1]};
                        count_d = count_q - 1'b1;
                    end
`else
                    data_d  = {fill, data_q[WIDTH-1:1]};
                    count_d = count_q - 1'b1;
`endif
                end
            end
            StDone: begin
                done_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_serial_right_shifter.sv
// Testbench for serial_right_shifter: scoreboard of expected results, checked on done.
module tb_serial_right_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks;
    int          n_fails;
    logic [31:0] sb[$];
    logic [31:0] last_result;

    serial_right_shifter #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data_in(data_in),
        .shamt  (shamt),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int s);
`ifdef SHIFT_FAST_STEP_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                check("result", result, sb.pop_front());
            end
        end
    end

    task automatic do_op(input logic [31:0] d, input int s, input logic a, input bit disturb);
        logic [31:0] exp;
        int          n;
        int          busy_n;
        bit          seen;
        exp = a ? $unsigned($signed(d) >>> s) : (d >> s);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        shamt   = s[4:0];
        arith   = a;
        sb.push_back(exp);
        n      = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (disturb && n == 3) begin
                start   = 1'b1;
                data_in = ~d;
                shamt   = 5'd1;
                arith   = ~a;
            end
            if (disturb && n == 4) start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_n++;
                check("result_hold", result, last_result);
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", n - 1, exp_lat(s));
            check("busy_cycles", busy_n, exp_lat(s));
            check("busy_at_done", {31'd0, busy}, 32'd0);
            last_result = exp;
            @(negedge clk);
            check("done_pulse", {31'd0, done}, 32'd0);
            check("result_after", result, exp);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        last_result = 32'd0;
        rst_n       = 1'b0;
        start       = 1'b0;
        data_in     = 32'd0;
        shamt       = 5'd0;
        arith       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h0000_0100, 2, 1'b0, 1'b0);
        do_op(32'h8000_0000, 31, 1'b1, 1'b0);
        check("msb_arith", last_result, 32'hFFFF_FFFF);
        do_op(32'h8000_0000, 31, 1'b0, 1'b0);
        check("msb_logic", last_result, 32'h0000_0001);
        do_op(32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        do_op(32'hF000_0000, 8, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("no_queued_op", {31'd0, busy}, 32'd0);

        // Reset in the middle of a long operation.
        @(negedge clk);
        start   = 1'b1;
        data_in = 32'hABCD_1234;
        shamt   = 5'd20;
        arith   = 1'b1;
        sb.push_back(32'hFFFF_FABC);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        sb.delete();
        last_result = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h0000_0010, 4, 1'b0, 1'b0);
        do_op(32'h8000_0000, 9, 1'b1, 1'b0);
        check("fast_case", last_result, 32'hFFC0_0000);

        for (int i = 0; i < 6; i++) begin
            do_op($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
